decrypt_checker: RTL and testbench
==================================

DECRYPT_CHECKER -- requirements
Module: decrypt_checker

Interface
REQ-001 Parameter MSG_LEN, default 32: number of decrypted bytes read from D RAM, range 1..256.
REQ-002 Parameter CHAR_LO, default 8'h61: lowest legal character ('a').
REQ-003 Parameter CHAR_HI, default 8'h7A: highest legal character ('z').
REQ-004 Parameter CHAR_SP, default 8'h20: additional legal character (space).
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 start  in  1  request to check the message currently held in D RAM.
REQ-008 finish  out  1  one-cycle pulse: check complete, valid/bad_index are final.
REQ-009 valid  out  1  1 = all MSG_LEN bytes legal.
REQ-010 bad_index  out  8  index of first illegal byte; 0 when valid=1.
REQ-011 address_d  out  8  D RAM read address.
REQ-012 q_d  in  8  D RAM read data, registered RAM, valid 2 cycles after address issue.
REQ-013 selector  out  1  1 while block owns D RAM port (drives top-level RAM mux), else 0.

Function
REQ-014 States SHALL be IDLE, READ, WAIT, CAPTURE, CHECK, DONE.
REQ-015 IDLE: start=1 -> READ with byte counter k cleared to 0; else stay IDLE.
REQ-016 READ: address_d <= k; -> WAIT.
REQ-017 WAIT: no action (RAM latency); -> CAPTURE.
REQ-018 CAPTURE: byte register <= q_d; -> CHECK.
REQ-019 CHECK: byte legal iff CHAR_LO<=byte<=CHAR_HI or byte==CHAR_SP (unsigned compare).
REQ-020 CHECK, illegal byte: valid<=0, bad_index<=k, -> DONE (early abort, no further reads).
REQ-021 CHECK, legal byte, k==MSG_LEN-1: valid<=1, bad_index<=0, -> DONE.
REQ-022 CHECK, legal byte, k<MSG_LEN-1: k<=k+1, -> READ.
REQ-023 k SHALL be 8 bits and never wrap past MSG_LEN-1 (MSG_LEN=256 terminates at k=255 without overflow use).
REQ-024 DONE: finish=1 for exactly this one cycle; -> IDLE unconditionally.
REQ-025 Per-byte cost exactly 4 cycles; full pass finish cycle = 4*MSG_LEN+1 cycles after the edge sampling start (129 for MSG_LEN=32).
REQ-026 start ignored in READ..DONE; start held high through DONE re-triggers on the following IDLE cycle.
REQ-027 valid and bad_index SHALL hold their values from DONE until the next CHECK that updates them; valid SHALL be cleared to 0 on leaving IDLE for READ.
REQ-028 selector=1 in READ, WAIT, CAPTURE, CHECK; 0 in IDLE and DONE.
REQ-029 No write enable is driven; the block never writes D RAM.

Reset
REQ-030 reset=0 at a clock edge SHALL force IDLE, k=0, address_d=0, byte register=0, valid=0, bad_index=0, finish=0, selector=0.
REQ-031 Reset asserted mid-check SHALL abort without a finish pulse; first start after release begins at k=0.

Structure
REQ-032 Shared package SHALL hold the state enum typedef and CHAR_LO/CHAR_HI/CHAR_SP defaults for reuse by the key-search controller.
REQ-033 One sub-module, char_is_legal (combinational 8-bit range/space test), SHALL implement REQ-019.
REQ-034 finish and selector SHALL be decoded from state, glitch-free registered state only.

Verification
REQ-035 D RAM = 32 x 8'h61, pulse start -> finish at cycle 129, valid=1, bad_index=0, addresses 0..31 each issued once.
REQ-036 Byte 5 = 8'h41, rest 8'h61 -> finish at cycle 25, valid=0, bad_index=5, no address >5 issued.
REQ-037 Byte 0 = 8'h7B, byte 31 = 8'h20 cases separately -> (7B) finish cycle 5, valid=0, bad_index=0; (20 at end, rest 'z') valid=1.
REQ-038 Reset low at cycle 40 of a legal run -> no finish, all outputs 0; new start -> full 129-cycle pass, valid=1.
REQ-039 start held high continuously with legal data -> finish every 130 cycles, start pulses during busy states cause no extra passes.

Source files
------------

// File: rtl/decrypt_checker_pkg.sv
// -----------------------------------------------------------------------------
// decrypt_checker_pkg
// Shared definitions for the decrypted-message checker and the key-search
// controller that drives it: the checker state encoding and the default
// legal-character set (lower-case letters plus space).
// -----------------------------------------------------------------------------
package decrypt_checker_pkg;

   // Checker state encoding; shared so the key-search controller can observe
   // or mirror the checker phase without redefining it.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_CHECK   = 3'd4,
      ST_DONE    = 3'd5
   } dc_state_e;

   // Default legal character set: 'a'..'z' and space.
   localparam logic [7:0] DEF_CHAR_LO = 8'h61;
   localparam logic [7:0] DEF_CHAR_HI = 8'h7A;
   localparam logic [7:0] DEF_CHAR_SP = 8'h20;

endpackage : decrypt_checker_pkg

// File: rtl/decrypt_checker_if.sv
// -----------------------------------------------------------------------------
// decrypt_checker_if
// Bundles the checker's control handshake and its D RAM read port.
//   start      : request to check the message currently in D RAM
//   finish     : one-cycle completion pulse
//   valid      : 1 = every byte legal
//   bad_index  : index of the first illegal byte (0 when valid)
//   address_d  : D RAM read address
//   q_d        : D RAM read data (registered RAM)
//   selector   : 1 while the checker owns the D RAM port
// The slave modport is the checker; the master modport is the surrounding
// controller / RAM side.
// -----------------------------------------------------------------------------
interface decrypt_checker_if;
   logic       start;
   logic       finish;
   logic       valid;
   logic [7:0] bad_index;
   logic [7:0] address_d;
   logic [7:0] q_d;
   logic       selector;

   modport slave (
      input  start,
      input  q_d,
      output finish,
      output valid,
      output bad_index,
      output address_d,
      output selector
   );

   modport master (
      output start,
      output q_d,
      input  finish,
      input  valid,
      input  bad_index,
      input  address_d,
      input  selector
   );
endinterface : decrypt_checker_if

// File: rtl/decrypt_checker_char_is_legal.sv
// -----------------------------------------------------------------------------
// char_is_legal
// Combinational legality test for one decrypted byte: legal when it lies in
// the unsigned range CHAR_LO..CHAR_HI or equals CHAR_SP.
//   byte_i  : byte under test
//   legal_o : 1 = legal character
// -----------------------------------------------------------------------------
module char_is_legal
   import decrypt_checker_pkg::*;
#(
   parameter logic [7:0] CHAR_LO = DEF_CHAR_LO,
   parameter logic [7:0] CHAR_HI = DEF_CHAR_HI,
   parameter logic [7:0] CHAR_SP = DEF_CHAR_SP
) (
   input  logic [7:0] byte_i,
   output logic       legal_o
);

   // Range test on unsigned operands, plus the single extra character.
   always_comb begin
      legal_o = 1'b0;
      if (((byte_i >= CHAR_LO) && (byte_i <= CHAR_HI)) || (byte_i == CHAR_SP)) begin
         legal_o = 1'b1;
      end else begin
         legal_o = 1'b0;
      end
   end

endmodule : char_is_legal

// File: rtl/decrypt_checker.sv
// -----------------------------------------------------------------------------
// decrypt_checker
// Reads MSG_LEN decrypted bytes from D RAM one at a time and reports whether
// every byte is a legal character. Stops at the first illegal byte and
// reports its index. Each byte costs four cycles: issue address, wait for the
// registered RAM, capture data, check.
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-low reset
//   bus    : decrypt_checker_if.slave (start/finish/valid/bad_index,
//            address_d/q_d read port, selector RAM-mux ownership)
// The block never writes D RAM.
// -----------------------------------------------------------------------------
module decrypt_checker
   import decrypt_checker_pkg::*;
#(
   parameter int          MSG_LEN = 32,
   parameter logic [7:0]  CHAR_LO = DEF_CHAR_LO,
   parameter logic [7:0]  CHAR_HI = DEF_CHAR_HI,
   parameter logic [7:0]  CHAR_SP = DEF_CHAR_SP
) (
   input  logic               clk,
   input  logic               reset,
   decrypt_checker_if.slave   bus
);

   // Last byte index; with MSG_LEN=256 this is 8'hFF so k never has to wrap.
   localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

   dc_state_e  state_q,     state_d;
   logic [7:0] k_q,         k_d;
   logic [7:0] addr_q,      addr_d;
   logic [7:0] byte_q,      byte_d;
   logic       valid_q,     valid_d;
   logic [7:0] bad_index_q, bad_index_d;
   logic       finish_q,    finish_d;
   logic       selector_q,  selector_d;
   logic       legal_s;

   char_is_legal #(
      .CHAR_LO (CHAR_LO),
      .CHAR_HI (CHAR_HI),
      .CHAR_SP (CHAR_SP)
   ) u_char_is_legal (
      .byte_i  (byte_q),
      .legal_o (legal_s)
   );

   // Next-state and datapath decisions for the byte-walk FSM.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      addr_d      = addr_q;
      byte_d      = byte_q;
      valid_d     = valid_q;
      bad_index_d = bad_index_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               k_d     = 8'd0;
               valid_d = 1'b0;
               state_d = ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            addr_d  = k_q;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            byte_d  = bus.q_d;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (!legal_s) begin
               // Early abort: no further reads after the first bad byte.
               valid_d     = 1'b0;
               bad_index_d = k_q;
               state_d     = ST_DONE;
            end else if (k_q == K_LAST) begin
               valid_d     = 1'b1;
               bad_index_d = 8'd0;
               state_d     = ST_DONE;
            end else begin
               k_d     = k_q + 8'd1;
               state_d = ST_READ;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so finish and
   // selector line up with the state register and never glitch.
   always_comb begin
      finish_d   = 1'b0;
      selector_d = 1'b0;
      case (state_d)
         ST_READ, ST_WAIT, ST_CAPTURE, ST_CHECK: begin
            finish_d   = 1'b0;
            selector_d = 1'b1;
         end
         ST_DONE: begin
            finish_d   = 1'b1;
            selector_d = 1'b0;
         end
         default: begin
            finish_d   = 1'b0;
            selector_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         k_q         <= 8'd0;
         addr_q      <= 8'd0;
         byte_q      <= 8'd0;
         valid_q     <= 1'b0;
         bad_index_q <= 8'd0;
         finish_q    <= 1'b0;
         selector_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         addr_q      <= addr_d;
         byte_q      <= byte_d;
         valid_q     <= valid_d;
         bad_index_q <= bad_index_d;
         finish_q    <= finish_d;
         selector_q  <= selector_d;
      end
   end

   assign bus.finish    = finish_q;
   assign bus.valid     = valid_q;
   assign bus.bad_index = bad_index_q;
   assign bus.address_d = addr_q;
   assign bus.selector  = selector_q;

endmodule : decrypt_checker

// File: tb/tb_decrypt_checker.sv
// -----------------------------------------------------------------------------
// tb_decrypt_checker
// Table-driven bench for decrypt_checker (MSG_LEN=32) with a registered D RAM
// model, plus hand-written sequences for reset mid-check and start held high.
// Cycle n is counted as the value present just before the n-th rising edge
// after the edge that samples start.
// -----------------------------------------------------------------------------
module tb_decrypt_checker;

   logic       clk;
   logic       reset;
   logic [7:0] mem [0:255];
   int         errors;
   int         checks;

   decrypt_checker_if bus ();

   decrypt_checker #(.MSG_LEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] fill;
      int         bad_pos;
      logic [7:0] bad_val;
      int         exp_cycle;
      int         exp_valid;
      int         exp_bi;
      int         exp_last;
   } vec_t;

   vec_t vecs [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered RAM: data for the address present at an edge appears after it.
   always @(posedge clk) bus.q_d <= mem[bus.address_d];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic load(input logic [7:0] fill, input int pos, input logic [7:0] val);
      for (int i = 0; i < 256; i++) mem[i] = fill;
      if (pos >= 0) mem[pos] = val;
   endtask

   // One start pulse, wait for finish, check timing, result and address usage.
   task automatic run_pass(input string tag, input int exp_cycle, input int exp_valid,
                           input int exp_bi, input int exp_last);
      int n;
      int maxa;
      int distinct;
      bit seen [256];
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      maxa = -1;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      n = 1;
      check({tag, " valid cleared on start"}, int'(bus.valid), 0);
      check({tag, " selector in READ"}, int'(bus.selector), 1);
      while (bus.finish !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
         if (bus.selector === 1'b1 && n >= 2) begin
            seen[bus.address_d] = 1'b1;
            if (int'(bus.address_d) > maxa) maxa = int'(bus.address_d);
         end
      end
      distinct = 0;
      for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
      check({tag, " finish cycle"}, n, exp_cycle);
      check({tag, " valid"}, int'(bus.valid), exp_valid);
      check({tag, " bad_index"}, int'(bus.bad_index), exp_bi);
      check({tag, " selector in DONE"}, int'(bus.selector), 0);
      check({tag, " max address"}, maxa, exp_last);
      check({tag, " distinct addresses"}, distinct, exp_last + 1);
      @(negedge clk);
      check({tag, " finish one cycle"}, int'(bus.finish), 0);
      repeat (3) @(negedge clk);
      check({tag, " valid held"}, int'(bus.valid), exp_valid);
      check({tag, " bad_index held"}, int'(bus.bad_index), exp_bi);
   endtask

   initial begin
      int n;
      int fin_cnt;
      int fin_at [4];
      bit fin_seen;

      errors    = 0;
      checks    = 0;
      reset     = 1'b0;
      bus.start = 1'b0;
      load(8'h61, -1, 8'h00);

      // Bad byte at position p finishes at 4p+5; a full pass at 4*32+1 = 129.
      vecs[0] = '{8'h61, -1, 8'h00, 129, 1,  0, 31};
      vecs[1] = '{8'h61,  5, 8'h41,  25, 0,  5,  5};
      vecs[2] = '{8'h61,  0, 8'h7B,   5, 0,  0,  0};
      vecs[3] = '{8'h7A, 31, 8'h20, 129, 1,  0, 31};
      vecs[4] = '{8'h7A, 31, 8'h7B, 129, 0, 31, 31};
      vecs[5] = '{8'h20, 10, 8'h60,  45, 0, 10, 10};
      vecs[6] = '{8'h61,  7, 8'h21,  33, 0,  7,  7};
      vecs[7] = '{8'h61,  3, 8'h7A, 129, 1,  0, 31};

      repeat (3) @(negedge clk);
      check("reset finish",    int'(bus.finish),    0);
      check("reset valid",     int'(bus.valid),     0);
      check("reset bad_index", int'(bus.bad_index), 0);
      check("reset address",   int'(bus.address_d), 0);
      check("reset selector",  int'(bus.selector),  0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         load(vecs[v].fill, vecs[v].bad_pos, vecs[v].bad_val);
         run_pass($sformatf("vec%0d", v), vecs[v].exp_cycle, vecs[v].exp_valid,
                  vecs[v].exp_bi, vecs[v].exp_last);
      end

      // Reset asserted at cycle 40 of a legal pass: no finish, outputs cleared.
      load(8'h61, -1, 8'h00);
      fin_seen = 1'b0;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      n = 1;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (bus.finish === 1'b1) fin_seen = 1'b1;
      end
      reset = 1'b0;
      @(negedge clk);
      check("midreset finish",    int'(bus.finish),    0);
      check("midreset valid",     int'(bus.valid),     0);
      check("midreset bad_index", int'(bus.bad_index), 0);
      check("midreset address",   int'(bus.address_d), 0);
      check("midreset selector",  int'(bus.selector),  0);
      repeat (2) @(negedge clk) if (bus.finish === 1'b1) fin_seen = 1'b1;
      reset = 1'b1;
      repeat (200) @(negedge clk) if (bus.finish === 1'b1) fin_seen = 1'b1;
      check("midreset no finish", int'(fin_seen), 0);
      run_pass("after reset", 129, 1, 0, 31);

      // start held high: a pass every 130 cycles, busy-time start is ignored.
      fin_cnt = 0;
      @(negedge clk) bus.start = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (bus.finish === 1'b1) begin
            if (fin_cnt < 4) fin_at[fin_cnt] = c;
            fin_cnt++;
         end
      end
      bus.start = 1'b0;
      check("held finish count", fin_cnt, 3);
      check("held first finish", (fin_cnt > 0) ? fin_at[0] : -1, 129);
      check("held period 1", (fin_cnt > 1) ? fin_at[1] - fin_at[0] : -1, 130);
      check("held period 2", (fin_cnt > 2) ? fin_at[2] - fin_at[1] : -1, 130);
      check("held valid", int'(bus.valid), 0);
      n = 0;
      while (bus.finish !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("held drain finish", int'(bus.finish), 1);
      check("held drain valid", int'(bus.valid), 1);
      repeat (3) @(negedge clk);
      check("held idle selector", int'(bus.selector), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_decrypt_checker
